icache_assoc: RTL and testbench
===============================

Name: icache_assoc

Overview:
Parametrised set-associative instruction cache; the next generation of the direct-mapped I-cache. It sits between fetch and the memory bus arbiter, using the same tagged-response memory protocol (request accepted via a non-zero response tag, data returned later on a matching tag). Over the previous generation it adds:
- configurable sets and ways, with tree pseudo-LRU replacement;
- a miss FSM that always completes an accepted fill even if fetch redirects;
- a single-cycle flush.

Parameters:
NUM_SETS, 16, number of sets; power of two, 2..64; INDEX_W = log2(NUM_SETS).
NUM_WAYS, 2, associativity; one of 1, 2, 4.
LINE_BYTES, 8, line size; fixed at 8 (one 64-bit memory beat); any other value is an elaboration error.

Ports:
clock  input  1  system clock; all state updates on posedge.
reset  input  1  synchronous, active-high reset.
proc2Icache_en  input  1  fetch request qualifier; only qualified hits update PLRU.
proc2Icache_addr  input  XLEN  fetch byte address; bits [2:0] ignored except bit 2 (word select).
icache_flush  input  1  invalidate all lines this cycle.
mem2Icache_response  input  4  memory acceptance tag; 0 = not accepted.
mem2Icache_response_valid  input  1  qualifies mem2Icache_response.
mem2Icache_data  input  64  returned line data.
mem2Icache_tag  input  4  tag of the data currently on mem2Icache_data; 0 = none.
Icache2proc_data  output  32  selected instruction word.
Icache2proc_valid  output  1  hit for the current address.
Icache2mem_command  output  BUS_COMMAND  BUS_NONE or BUS_LOAD.
Icache2mem_addr  output  XLEN  8-byte-aligned line address.
icache_busy  output  1  miss FSM not in IDLE.

Behaviour:
- Address split: offset [2:0]; index [INDEX_W+2:3]; tag = remaining upper bits.
- Lookup is combinational, with zero-cycle latency:
  - Icache2proc_valid = OR over ways of (valid & tag match) & ~icache_flush.
  - Data comes from the hitting way; addr[2] selects the upper (1) or lower (0) 32-bit word.
  - At most one way may match; a multi-hit is an assertion failure.
- Qualified hit (proc2Icache_en & valid): the set's PLRU tree is updated to mark the hit way MRU at the clock edge.
- Victim selection: lowest-numbered invalid way first; otherwise the PLRU victim. When NUM_WAYS=1, the victim is always way 0.
- Miss FSM states: IDLE, REQ, WAIT.
  - IDLE -> REQ: when proc2Icache_en & ~Icache2proc_valid & ~icache_flush. The line address, index and tag are latched (miss_line).
  - REQ:
    - Drive BUS_LOAD with Icache2mem_addr = miss_line.
    - If mem2Icache_response_valid & response != 0: capture mem_tag and go to WAIT.
    - If response_valid with response == 0: stay in REQ and retry next cycle.
    - If the fetch address line differs from miss_line, or flush is asserted: return to IDLE without capturing; that cycle's command is BUS_NONE.
  - WAIT:
    - Command is BUS_NONE.
    - When mem2Icache_tag == mem_tag, write the data, tag and valid bit into the victim way of the latched set, mark that way MRU, and go to IDLE.
    - A fetch redirect does NOT abandon the fill.
- Icache2mem_command is BUS_NONE outside REQ. Icache2mem_addr equals miss_line in REQ and is don't-care otherwise (drive miss_line).
- Flush:
  - All valid bits clear at the edge; PLRU state is left unchanged.
  - In REQ, the FSM returns to IDLE.
  - In WAIT, the FSM sets drop_fill. The matching data is consumed without writing, and the FSM goes to IDLE.
- Same-cycle fill and hit on the same set: both PLRU updates apply, and the fill's update wins.
- Reset:
  - All valid bits, PLRU bits, mem_tag and drop_fill clear; FSM goes to IDLE.
  - Outputs after reset: command BUS_NONE, Icache2proc_valid 0, icache_busy 0.
  - Reset during WAIT: any later returning data is ignored.

Optional Feature:
ICACHE_PREFETCH_EN
- Defined:
  - After a demand fill completes, if line miss_line+8 misses in its set, the FSM enters PF_REQ then PF_WAIT, which behave like REQ/WAIT for that line.
  - A prefetch fill does not update PLRU.
  - A demand miss to a different line while in PF_REQ cancels the prefetch and starts the demand request in that cycle.
  - In PF_WAIT, a demand miss waits until the prefetch completes.
  - Flush cancels the prefetch using the same rules as for demand fills.
- Undefined: PF states do not exist; behaviour is exactly as above.

Test Plan:
- Cold miss: reset, addr 0x100, en=1 -> valid=0 and BUS_LOAD 0x100 on the next cycle; response=3; tag=3 with data 0xDEADBEEF_12345678 -> valid=1, data 0x12345678; addr 0x104 -> 0xDEADBEEF.
- Busy memory: response_valid=1 with response=0 for 3 cycles -> BUS_LOAD held 4 cycles; response=5 -> WAIT, BUS_NONE.
- Associativity and LRU (defaults: 2 ways, 16 sets): fill 0x000 and 0x080 (same set), hit 0x000, then miss 0x100 -> 0x080 evicted, while 0x000 and 0x100 both hit.
- Redirect in WAIT: miss 0x200, tag 2 accepted, addr changes to 0x300 -> line 0x200 is still installed on tag 2, then BUS_LOAD 0x300.
- Flush mid-fill: flush in WAIT -> all lines miss, returning data is not written, FSM reaches IDLE, busy=0.
- Prefetch (macro on): demand fill 0x400 completes -> BUS_LOAD 0x408 follows; after its fill, 0x408 hits with no further request.

Source files
------------

// File: rtl/icache_assoc.sv
// icache_assoc: set-associative instruction cache with tree-PLRU replacement, a tagged-response
// miss FSM and single-cycle flush. Define ICACHE_PREFETCH_EN to enable next-line prefetch.
module icache_assoc #(
  parameter int XLEN       = 32,
  parameter int NUM_SETS   = 16,
  parameter int NUM_WAYS   = 2,
  parameter int LINE_BYTES = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            proc2Icache_en,
  input  logic [XLEN-1:0] proc2Icache_addr,
  input  logic            icache_flush,
  input  logic [3:0]      mem2Icache_response,
  input  logic            mem2Icache_response_valid,
  input  logic [63:0]     mem2Icache_data,
  input  logic [3:0]      mem2Icache_tag,
  output logic [31:0]     Icache2proc_data,
  output logic            Icache2proc_valid,
  output logic [1:0]      Icache2mem_command,
  output logic [XLEN-1:0] Icache2mem_addr,
  output logic            icache_busy
);

  // state   | meaning
  // IDLE    | no miss outstanding
  // REQ     | BUS_LOAD of miss_line until memory accepts with a non-zero tag
  // WAIT    | request accepted, waiting for data carrying mem_tag
  // PF_REQ  | next-line prefetch request (ICACHE_PREFETCH_EN only)
  // PF_WAIT | prefetch accepted, waiting for its data (ICACHE_PREFETCH_EN only)

  localparam logic [1:0] BUS_NONE = 2'd0;
  localparam logic [1:0] BUS_LOAD = 2'd1;

  localparam int INDEX_W = $clog2(NUM_SETS);
  localparam int LINE_W  = XLEN - 3;
  localparam int TAG_W   = XLEN - 3 - INDEX_W;

  if (LINE_BYTES != 8) begin : g_bad_line_bytes
    $error("icache_assoc: LINE_BYTES must be 8");
  end
  if (NUM_WAYS != 1 && NUM_WAYS != 2 && NUM_WAYS != 4) begin : g_bad_num_ways
    $error("icache_assoc: NUM_WAYS must be 1, 2 or 4");
  end
  if (NUM_SETS < 2 || NUM_SETS > 64 || (1 << INDEX_W) != NUM_SETS) begin : g_bad_num_sets
    $error("icache_assoc: NUM_SETS must be a power of two in 2..64");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
`ifdef ICACHE_PREFETCH_EN
    ,
    S_PF_REQ,
    S_PF_WAIT
`endif
  } state_e;

  state_e              state_q, state_d;
  logic [LINE_W-1:0]   miss_line_q, miss_line_d;
  logic [3:0]          mem_tag_q, mem_tag_d;
  logic                drop_fill_q, drop_fill_d;
  logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0] valid_d [NUM_SETS];
  logic [2:0]          plru_q  [NUM_SETS];
  logic [2:0]          plru_d  [NUM_SETS];

  logic [TAG_W-1:0]    tag_mem  [NUM_SETS][NUM_WAYS];
  logic [63:0]         data_mem [NUM_SETS][NUM_WAYS];

  logic [LINE_W-1:0]   fetch_line;
  logic [INDEX_W-1:0]  fetch_idx, miss_idx;
  logic [TAG_W-1:0]    fetch_tag, miss_tag;
  logic [NUM_WAYS-1:0] hit_vec;
  logic                hit_any;
  logic [1:0]          hit_way;
  logic [63:0]         hit_line;
  logic [1:0]          victim;
  logic [NUM_WAYS-1:0] victim_oh;
  logic                demand_miss;
  logic                fill_we, fill_touch;
  logic                unused_addr_bits;

  assign fetch_line       = proc2Icache_addr[XLEN-1:3];
  assign fetch_idx        = fetch_line[INDEX_W-1:0];
  assign fetch_tag        = fetch_line[LINE_W-1:INDEX_W];
  assign miss_idx         = miss_line_q[INDEX_W-1:0];
  assign miss_tag         = miss_line_q[LINE_W-1:INDEX_W];
  assign unused_addr_bits = ^proc2Icache_addr[1:0];

  // Tree bits point at the LRU side: bit0 root, bit1 over ways 0/1, bit2 over ways 2/3.
  function automatic logic [2:0] plru_touch(input logic [2:0] bits, input logic [1:0] way);
    logic [2:0] r;
    r = bits;
    if (NUM_WAYS == 2) begin
      r[0] = ~way[0];
    end else if (NUM_WAYS == 4) begin
      r[0] = ~way[1];
      if (way[1]) r[2] = ~way[0];
      else        r[1] = ~way[0];
    end
    return r;
  endfunction

  function automatic logic [1:0] plru_victim(input logic [2:0] bits);
    logic [1:0] v;
    if (NUM_WAYS == 2)      v = {1'b0, bits[0]};
    else if (NUM_WAYS == 4) v = bits[0] ? {1'b1, bits[2]} : {1'b0, bits[1]};
    else                    v = 2'd0;
    return v;
  endfunction

  always_comb begin
    hit_vec  = '0;
    hit_way  = 2'd0;
    hit_line = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      hit_vec[w] = valid_q[fetch_idx][w] && (tag_mem[fetch_idx][w] == fetch_tag);
      if (hit_vec[w]) begin
        hit_way  = 2'(w);
        hit_line = hit_line | data_mem[fetch_idx][w];
      end
    end
  end

  assign hit_any           = |hit_vec;
  assign Icache2proc_valid = hit_any & ~icache_flush;
  assign Icache2proc_data  = proc2Icache_addr[2] ? hit_line[63:32] : hit_line[31:0];
  assign demand_miss       = proc2Icache_en & ~hit_any & ~icache_flush;

  always_comb begin
    logic found;
    found  = 1'b0;
    victim = plru_victim(plru_q[miss_idx]);
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!found && !valid_q[miss_idx][w]) begin
        victim = 2'(w);
        found  = 1'b1;
      end
    end
    for (int w = 0; w < NUM_WAYS; w++) victim_oh[w] = (victim == 2'(w));
  end

`ifdef ICACHE_PREFETCH_EN
  logic [LINE_W-1:0]  pf_line;
  logic [INDEX_W-1:0] pf_idx;
  logic [TAG_W-1:0]   pf_tag;
  logic               pf_hit;

  always_comb begin
    pf_line = miss_line_q + LINE_W'(1);
    pf_idx  = pf_line[INDEX_W-1:0];
    pf_tag  = pf_line[LINE_W-1:INDEX_W];
    pf_hit  = 1'b0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[pf_idx][w] && (tag_mem[pf_idx][w] == pf_tag)) pf_hit = 1'b1;
    end
  end
`endif

  always_comb begin
    state_d            = state_q;
    miss_line_d        = miss_line_q;
    mem_tag_d          = mem_tag_q;
    drop_fill_d        = drop_fill_q;
    Icache2mem_command = BUS_NONE;
    fill_we            = 1'b0;
    fill_touch         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (demand_miss) begin
          state_d     = S_REQ;
          miss_line_d = fetch_line;
        end
      end
      S_REQ: begin
        if (icache_flush || (fetch_line != miss_line_q)) begin
          state_d = S_IDLE;
        end else begin
          Icache2mem_command = BUS_LOAD;
          if (mem2Icache_response_valid && (mem2Icache_response != 4'd0)) begin
            mem_tag_d = mem2Icache_response;
            state_d   = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // The fill always completes; only a flush can turn it into a discard.
        if (mem2Icache_tag == mem_tag_q) begin
          state_d     = S_IDLE;
          drop_fill_d = 1'b0;
          if (!drop_fill_q && !icache_flush) begin
            fill_we    = 1'b1;
            fill_touch = 1'b1;
`ifdef ICACHE_PREFETCH_EN
            if (!pf_hit) begin
              state_d     = S_PF_REQ;
              miss_line_d = miss_line_q + LINE_W'(1);
            end
`endif
          end
        end else if (icache_flush) begin
          drop_fill_d = 1'b1;
        end
      end
`ifdef ICACHE_PREFETCH_EN
      S_PF_REQ: begin
        if (icache_flush) begin
          state_d = S_IDLE;
        end else if (demand_miss && (fetch_line != miss_line_q)) begin
          state_d     = S_REQ;
          miss_line_d = fetch_line;
        end else begin
          Icache2mem_command = BUS_LOAD;
          if (mem2Icache_response_valid && (mem2Icache_response != 4'd0)) begin
            mem_tag_d = mem2Icache_response;
            state_d   = S_PF_WAIT;
          end
        end
      end
      S_PF_WAIT: begin
        if (mem2Icache_tag == mem_tag_q) begin
          state_d     = S_IDLE;
          drop_fill_d = 1'b0;
          fill_we     = !drop_fill_q && !icache_flush;
        end else if (icache_flush) begin
          drop_fill_d = 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign Icache2mem_addr = {miss_line_q, 3'b000};
  assign icache_busy     = (state_q != S_IDLE);

  // A hit and a fill to the same set both apply; the fill is applied last so it wins.
  always_comb begin
    plru_d  = plru_q;
    valid_d = valid_q;
    if (proc2Icache_en && Icache2proc_valid) plru_d[fetch_idx] = plru_touch(plru_d[fetch_idx], hit_way);
    if (fill_touch) plru_d[miss_idx] = plru_touch(plru_d[miss_idx], victim);
    if (icache_flush) begin
      for (int s = 0; s < NUM_SETS; s++) valid_d[s] = '0;
    end
    if (fill_we) valid_d[miss_idx] = valid_d[miss_idx] | victim_oh;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      miss_line_q <= '0;
      mem_tag_q   <= '0;
      drop_fill_q <= 1'b0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      miss_line_q <= miss_line_d;
      mem_tag_q   <= mem_tag_d;
      drop_fill_q <= drop_fill_d;
      valid_q     <= valid_d;
      plru_q      <= plru_d;
    end
  end

  always_ff @(posedge clock) begin
    if (fill_we) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (victim_oh[w]) begin
          tag_mem[miss_idx][w]  <= miss_tag;
          data_mem[miss_idx][w] <= mem2Icache_data;
        end
      end
    end
  end

  always @(posedge clock) begin
    if (!reset) begin
      a_single_hit: assert ($onehot0(hit_vec));
    end
  end

endmodule

// File: tb/tb_icache_assoc.sv
// Directed bench for icache_assoc: expectations are queued when stimulus is applied and
// popped against the DUT outputs at each check point.
module tb_icache_assoc;
  localparam logic [1:0] BUS_NONE = 2'd0;
  localparam logic [1:0] BUS_LOAD = 2'd1;

  logic        clock = 1'b0;
  logic        reset;
  logic        proc2Icache_en;
  logic [31:0] proc2Icache_addr;
  logic        icache_flush;
  logic [3:0]  mem2Icache_response;
  logic        mem2Icache_response_valid;
  logic [63:0] mem2Icache_data;
  logic [3:0]  mem2Icache_tag;
  logic [31:0] Icache2proc_data;
  logic        Icache2proc_valid;
  logic [1:0]  Icache2mem_command;
  logic [31:0] Icache2mem_addr;
  logic        icache_busy;

  int          n_assert = 0;
  int          n_fail   = 0;
  string       name_q[$];
  logic [63:0] val_q[$];

  icache_assoc dut (
    .clock                     (clock),
    .reset                     (reset),
    .proc2Icache_en            (proc2Icache_en),
    .proc2Icache_addr          (proc2Icache_addr),
    .icache_flush              (icache_flush),
    .mem2Icache_response       (mem2Icache_response),
    .mem2Icache_response_valid (mem2Icache_response_valid),
    .mem2Icache_data           (mem2Icache_data),
    .mem2Icache_tag            (mem2Icache_tag),
    .Icache2proc_data          (Icache2proc_data),
    .Icache2proc_valid         (Icache2proc_valid),
    .Icache2mem_command        (Icache2mem_command),
    .Icache2mem_addr           (Icache2mem_addr),
    .icache_busy               (icache_busy)
  );

  always #5 clock = ~clock;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_val(input string nm, input logic [63:0] v);
    name_q.push_back(nm);
    val_q.push_back(v);
  endtask

  task automatic chk(input logic [63:0] obs);
    string       nm;
    logic [63:0] ex;
    n_assert++;
    if (val_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty observed=%0h expected=<none>", obs);
      return;
    end
    nm = name_q.pop_front();
    ex = val_q.pop_front();
    assert (obs === ex) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", nm, obs, ex);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    proc2Icache_en = 1'b0;
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic wait_load(input string nm);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      if (Icache2mem_command == BUS_LOAD) got = 1'b1;
    end
    expect_val(nm, 64'd1);
    chk(64'(got));
  endtask

  task automatic fill_line(input string nm, input logic [31:0] a, input logic [3:0] t,
                           input logic [63:0] d);
    proc2Icache_addr = a;
    proc2Icache_en   = 1'b1;
    wait_load({nm, "_req"});
    expect_val({nm, "_addr"}, 64'(a & ~32'h7));
    chk(64'(Icache2mem_addr));
    mem2Icache_response_valid = 1'b1;
    mem2Icache_response       = t;
    tick();
    mem2Icache_response_valid = 1'b0;
    mem2Icache_response       = 4'd0;
    mem2Icache_tag            = t;
    mem2Icache_data           = d;
    tick();
    mem2Icache_tag = 4'd0;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    proc2Icache_en = 1'b0;
    proc2Icache_addr = '0;
    icache_flush = 1'b0;
    mem2Icache_response = '0;
    mem2Icache_response_valid = 1'b0;
    mem2Icache_data = '0;
    mem2Icache_tag = '0;
    tick();
    tick();
    reset = 1'b0;
    expect_val("reset_cmd", 64'(BUS_NONE));
    expect_val("reset_valid", 64'd0);
    expect_val("reset_busy", 64'd0);
    #1;
    chk(64'(Icache2mem_command));
    chk(64'(Icache2proc_valid));
    chk(64'(icache_busy));

    // cold miss
    proc2Icache_addr = 32'h100;
    proc2Icache_en = 1'b1;
    expect_val("cold_valid", 64'd0);
    #1;
    chk(64'(Icache2proc_valid));
    tick();
    expect_val("cold_cmd", 64'(BUS_LOAD));
    expect_val("cold_addr", 64'h100);
    expect_val("cold_busy", 64'd1);
    chk(64'(Icache2mem_command));
    chk(64'(Icache2mem_addr));
    chk(64'(icache_busy));
    mem2Icache_response_valid = 1'b1;
    mem2Icache_response = 4'd3;
    tick();
    mem2Icache_response_valid = 1'b0;
    mem2Icache_response = 4'd0;
    expect_val("cold_wait_cmd", 64'(BUS_NONE));
    #1;
    chk(64'(Icache2mem_command));
    mem2Icache_tag = 4'd3;
    mem2Icache_data = 64'hDEADBEEF_12345678;
    tick();
    mem2Icache_tag = 4'd0;
    expect_val("cold_hit_valid", 64'd1);
    expect_val("cold_hit_lo", 64'h12345678);
    #1;
    chk(64'(Icache2proc_valid));
    chk(64'(Icache2proc_data));
    proc2Icache_addr = 32'h104;
    expect_val("cold_hit_hi", 64'hDEADBEEF);
    expect_val("cold_idle_busy", 64'd0);
    #1;
    chk(64'(Icache2proc_data));
    chk(64'(icache_busy));

    // memory refuses three times, accepts on the fourth REQ cycle
    proc2Icache_addr = 32'h048;
    tick();
    mem2Icache_response_valid = 1'b1;
    mem2Icache_response = 4'd0;
    for (int i = 0; i < 3; i++) begin
      expect_val("busy_hold_cmd", 64'(BUS_LOAD));
      #1;
      chk(64'(Icache2mem_command));
      tick();
    end
    mem2Icache_response = 4'd5;
    expect_val("busy_hold_cmd4", 64'(BUS_LOAD));
    #1;
    chk(64'(Icache2mem_command));
    tick();
    mem2Icache_response_valid = 1'b0;
    mem2Icache_response = 4'd0;
    expect_val("busy_wait_cmd", 64'(BUS_NONE));
    expect_val("busy_wait_busy", 64'd1);
    #1;
    chk(64'(Icache2mem_command));
    chk(64'(icache_busy));
    mem2Icache_tag = 4'd4;
    mem2Icache_data = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    mem2Icache_tag = 4'd0;
    expect_val("wrong_tag_busy", 64'd1);
    expect_val("wrong_tag_valid", 64'd0);
    #1;
    chk(64'(icache_busy));
    chk(64'(Icache2proc_valid));
    mem2Icache_tag = 4'd5;
    mem2Icache_data = 64'h01234567_89ABCDEF;
    tick();
    mem2Icache_tag = 4'd0;
    expect_val("busy_fill_valid", 64'd1);
    expect_val("busy_fill_data", 64'h89ABCDEF);
    #1;
    chk(64'(Icache2proc_valid));
    chk(64'(Icache2proc_data));

    // two-way set 0: the hit on 0x000 makes 0x080 the PLRU victim
    do_reset();
    fill_line("lru_a", 32'h000, 4'd1, 64'h11111111_00000A0A);
    fill_line("lru_b", 32'h080, 4'd2, 64'h22222222_00000B0B);
    proc2Icache_addr = 32'h000;
    expect_val("lru_hit_a", 64'd1);
    #1;
    chk(64'(Icache2proc_valid));
    tick();
    fill_line("lru_c", 32'h100, 4'd3, 64'h33333333_00000C0C);
    proc2Icache_en = 1'b0;
    proc2Icache_addr = 32'h000;
    expect_val("lru_keep_a_valid", 64'd1);
    expect_val("lru_keep_a_data", 64'h00000A0A);
    #1;
    chk(64'(Icache2proc_valid));
    chk(64'(Icache2proc_data));
    proc2Icache_addr = 32'h100;
    expect_val("lru_new_c_valid", 64'd1);
    expect_val("lru_new_c_data", 64'h00000C0C);
    #1;
    chk(64'(Icache2proc_valid));
    chk(64'(Icache2proc_data));
    proc2Icache_addr = 32'h080;
    expect_val("lru_evict_b", 64'd0);
    #1;
    chk(64'(Icache2proc_valid));

    // redirect during WAIT still installs the line
    do_reset();
    proc2Icache_addr = 32'h200;
    proc2Icache_en = 1'b1;
    wait_load("redir_req");
    mem2Icache_response_valid = 1'b1;
    mem2Icache_response = 4'd2;
    tick();
    mem2Icache_response_valid = 1'b0;
    mem2Icache_response = 4'd0;
    proc2Icache_addr = 32'h300;
    tick();
    expect_val("redir_wait_busy", 64'd1);
    expect_val("redir_wait_cmd", 64'(BUS_NONE));
    chk(64'(icache_busy));
    chk(64'(Icache2mem_command));
    mem2Icache_tag = 4'd2;
    mem2Icache_data = 64'h44444444_00000D0D;
    tick();
    mem2Icache_tag = 4'd0;
    proc2Icache_addr = 32'h204;
    expect_val("redir_installed_valid", 64'd1);
    expect_val("redir_installed_data", 64'h44444444);
    #1;
    chk(64'(Icache2proc_valid));
    chk(64'(Icache2proc_data));
    proc2Icache_addr = 32'h300;
    expect_val("redir_new_miss", 64'd0);
    #1;
    chk(64'(Icache2proc_valid));
    tick();
    expect_val("redir_new_cmd", 64'(BUS_LOAD));
    expect_val("redir_new_addr", 64'h300);
    chk(64'(Icache2mem_command));
    chk(64'(Icache2mem_addr));
    proc2Icache_addr = 32'h200;
    expect_val("req_redirect_cmd", 64'(BUS_NONE));
    #1;
    chk(64'(Icache2mem_command));
    tick();
    expect_val("req_redirect_busy", 64'd0);
    chk(64'(icache_busy));

    // flush during WAIT discards the returning data
    proc2Icache_addr = 32'h500;
    wait_load("flush_req");
    mem2Icache_response_valid = 1'b1;
    mem2Icache_response = 4'd7;
    tick();
    mem2Icache_response_valid = 1'b0;
    mem2Icache_response = 4'd0;
    proc2Icache_addr = 32'h200;
    icache_flush = 1'b1;
    expect_val("flush_masks_hit", 64'd0);
    #1;
    chk(64'(Icache2proc_valid));
    tick();
    icache_flush = 1'b0;
    expect_val("flushed_line_miss", 64'd0);
    expect_val("flush_wait_busy", 64'd1);
    #1;
    chk(64'(Icache2proc_valid));
    chk(64'(icache_busy));
    mem2Icache_tag = 4'd7;
    mem2Icache_data = 64'h55555555_00000E0E;
    tick();
    mem2Icache_tag = 4'd0;
    proc2Icache_en = 1'b0;
    proc2Icache_addr = 32'h500;
    expect_val("flush_drop_busy", 64'd0);
    expect_val("flush_drop_valid", 64'd0);
    expect_val("flush_drop_cmd", 64'(BUS_NONE));
    #1;
    chk(64'(icache_busy));
    chk(64'(Icache2proc_valid));
    chk(64'(Icache2mem_command));

    // flush during REQ abandons the request
    proc2Icache_addr = 32'h600;
    proc2Icache_en = 1'b1;
    tick();
    expect_val("flush_req_cmd_before", 64'(BUS_LOAD));
    chk(64'(Icache2mem_command));
    icache_flush = 1'b1;
    expect_val("flush_req_cmd", 64'(BUS_NONE));
    #1;
    chk(64'(Icache2mem_command));
    tick();
    icache_flush = 1'b0;
    proc2Icache_en = 1'b0;
    expect_val("flush_req_busy", 64'd0);
    #1;
    chk(64'(icache_busy));

    // reset during WAIT: the late data must be ignored
    proc2Icache_addr = 32'h700;
    proc2Icache_en = 1'b1;
    wait_load("rstwait_req");
    mem2Icache_response_valid = 1'b1;
    mem2Icache_response = 4'd9;
    tick();
    mem2Icache_response_valid = 1'b0;
    mem2Icache_response = 4'd0;
    proc2Icache_en = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mem2Icache_tag = 4'd9;
    mem2Icache_data = 64'h66666666_00000F0F;
    tick();
    mem2Icache_tag = 4'd0;
    expect_val("rstwait_valid", 64'd0);
    expect_val("rstwait_busy", 64'd0);
    #1;
    chk(64'(Icache2proc_valid));
    chk(64'(icache_busy));

    // next-line prefetch after a demand fill
    do_reset();
    fill_line("pf_demand", 32'h400, 4'd4, 64'h77777777_00001111);
`ifdef ICACHE_PREFETCH_EN
    expect_val("pf_cmd", 64'(BUS_LOAD));
    expect_val("pf_addr", 64'h408);
    chk(64'(Icache2mem_command));
    chk(64'(Icache2mem_addr));
    mem2Icache_response_valid = 1'b1;
    mem2Icache_response = 4'd6;
    tick();
    mem2Icache_response_valid = 1'b0;
    mem2Icache_response = 4'd0;
    mem2Icache_tag = 4'd6;
    mem2Icache_data = 64'h88888888_00002222;
    tick();
    mem2Icache_tag = 4'd0;
    proc2Icache_addr = 32'h408;
    expect_val("pf_hit_valid", 64'd1);
    expect_val("pf_hit_data", 64'h00002222);
    #1;
    chk(64'(Icache2proc_valid));
    chk(64'(Icache2proc_data));
    tick();
    expect_val("pf_no_req_cmd", 64'(BUS_NONE));
    expect_val("pf_no_req_busy", 64'd0);
    chk(64'(Icache2mem_command));
    chk(64'(icache_busy));
`else
    expect_val("nopf_cmd", 64'(BUS_NONE));
    expect_val("nopf_busy", 64'd0);
    chk(64'(Icache2mem_command));
    chk(64'(icache_busy));
    proc2Icache_en = 1'b0;
    proc2Icache_addr = 32'h408;
    expect_val("nopf_next_miss", 64'd0);
    #1;
    chk(64'(Icache2proc_valid));
`endif

    if (val_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", val_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
